aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Round sequencer for the iterative AES core. It sits directly downstream of the AES control FSM: it consumes that FSM's busy indication, steps the datapath through AddRoundKey plus Nr rounds, and returns the one-cycle completion flag that moves the FSM from BUSY to DONE. It supplies the round index, round constant and first/last-round qualifiers to the round datapath and the key-expansion unit.

## Interface
- `NR_W`, default 4: round-index width; must hold 14.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_busy`  in  1  busy level from the control FSM; a rising edge starts a sequence.
- `i_key_len`  in  2  key length: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = treated as AES-128; sampled on the start cycle.
- `i_hold`  in  1  stall from the key-expansion unit (round key not ready).
- `o_round`  out  NR_W  current round index, 0..Nr.
- `o_rcon`  out  8  round constant for the current round.
- `o_round_en`  out  1  datapath executes the current round this cycle.
- `o_first_round`  out  1  round 0 (initial AddRoundKey only).
- `o_last_round`  out  1  round Nr (no MixColumns).
- `o_flag`  out  1  one-cycle completion pulse, driven to the FSM `i_flag`.

## Operation
- Nr is 10, 12 or 14. It comes from `i_key_len` latched at start; it is held in `nr_q` for the whole sequence.
- Start is `i_busy & ~busy_q`, where `busy_q` is a registered copy of `i_busy`. A busy level that stays high never retriggers.
- The states are IDLE, INIT, ROUND and FLAG.
- IDLE:
  - Outputs inactive.
  - On start: latch Nr, set `o_round`=0 and `o_rcon`=8'h01, then go to INIT.
- INIT:
  - `o_first_round`=1.
  - If `~i_hold`: `o_round`←1 and go to ROUND.
- ROUND:
  - If `~i_hold` and `o_round`<Nr: `o_round`++ and `o_rcon`←xtime(`o_rcon`) (left shift by one; XOR 8'h1b if bit 7 was set).
  - If `~i_hold` and `o_round`==Nr: go to FLAG.
- FLAG:
  - `o_flag`=1 for exactly one cycle, then go to IDLE.
- `o_rcon` sequence as rounds 1..10 execute: 01,02,04,08,10,20,40,80,1b,36. It continues the xtime sequence for rounds 11..14.
- `o_round_en` = (INIT or ROUND) & ~`i_hold`. It is combinational on `i_hold`; all other outputs are registered or decoded from state.
- `o_last_round` = ROUND & (`o_round`==Nr).
- Abort: if `i_busy` falls in INIT or ROUND, return to IDLE next cycle with no `o_flag`. `o_round` and `o_rcon` are cleared.
- A start seen in FLAG is ignored. A start on the IDLE cycle right after FLAG is accepted.

## Timing
- Reset values: state IDLE, `o_round`=0, `o_rcon`=8'h00, `busy_q`=0. `o_round_en`, `o_first_round`, `o_last_round` and `o_flag` are all 0.
- Reset is synchronous and wins over every other event, including a start in the same cycle.
- Latency with no holds:
  - cycle 0: rising `i_busy` sampled.
  - cycle 1: INIT, round 0.
  - cycles 2..Nr+1: rounds 1..Nr.
  - cycle Nr+2: `o_flag`.
- This gives 12, 14 or 16 cycles from start to flag.
- Each cycle of `i_hold` during INIT/ROUND adds exactly one cycle. `i_hold` is ignored in IDLE and FLAG.
- `o_flag` is seen in the FSM's BUSY state. The FSM reaches DONE on the next cycle and `i_busy` falls one cycle after the flag.

## Structure
- Shared package `aes_pkg`:
  - key-length encodings;
  - NR_128/192/256 = 10/12/14;
  - RCON_INIT = 8'h01;
  - the xtime function (shared with MixColumns);
  - sequencer state encoding.
- One natural sub-module: `aes_rcon_gen`, a registered rcon with load and step inputs. Everything else stays in the sequencer.

## Test plan
- AES-128, no hold, busy rises at cycle 0:
  - `o_first_round`@1;
  - `o_round` 1..10 @2..11;
  - `o_last_round`@11;
  - `o_flag`@12 only;
  - rcon 01..36 as listed.
- AES-192 and AES-256, no hold: `o_flag`@14 and @16 respectively; final `o_round` = 12 and 14; the key length code 3 behaves as AES-128.
- AES-128 with `i_hold` high for 3 cycles in INIT and 2 cycles at round 5:
  - `o_round_en` low exactly those 5 cycles;
  - `o_round` frozen during them;
  - `o_flag`@17.
- `i_busy` dropped at round 4: IDLE next cycle, no `o_flag`, `o_round`=0. A new busy rise then starts from round 0 with rcon 01.
- `rst` asserted at round 7 with `i_busy` still high:
  - all outputs reset next cycle;
  - no restart while `i_busy` stays high;
  - a restart only after `i_busy` goes low then high.
- Closed loop with the AES control FSM: enable pulse → BUSY → 12 cycles → DONE with valid for 1 cycle → FSM back to WAIT. Back-to-back enables produce one flag each.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, xtime helper and round-sequencer state encoding
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // GF(2^8) multiply by x, reduced by the AES polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_INIT  = 2'd1,
        SEQ_ROUND = 2'd2,
        SEQ_FLAG  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - registered AES round constant with clear, load and xtime step
module aes_rcon_gen (
    input  logic       clk,   // rising-edge clock
    input  logic       rst,   // synchronous active-high reset
    input  logic       clear, // drive rcon to zero (idle value)
    input  logic       load,  // restart the sequence at RCON_INIT
    input  logic       step,  // advance to the next round constant
    output logic [7:0] rcon   // current round constant
);
    import aes_pkg::*;

    // clear beats load beats step; the sequencer never raises two at once
    always_ff @(posedge clk) begin
        if (rst) begin
            rcon <= 8'h00;
        end else if (clear) begin
            rcon <= 8'h00;
        end else if (load) begin
            rcon <= RCON_INIT;
        end else if (step) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - steps the iterative AES datapath through round 0..Nr and flags completion
module aes_round_sequencer #(
    parameter int NR_W = 4                  // round-index width, must hold 14
) (
    input  logic            clk,            // rising-edge clock
    input  logic            rst,            // synchronous active-high reset
    input  logic            i_busy,         // busy level from control FSM, rising edge starts
    input  logic [1:0]      i_key_len,      // 0:128 1:192 2:256 3:128, sampled at start
    input  logic            i_hold,         // round key not ready, stall
    output logic [NR_W-1:0] o_round,        // current round index
    output logic [7:0]      o_rcon,         // round constant for current round
    output logic            o_round_en,     // datapath executes this round now
    output logic            o_first_round,  // round 0, AddRoundKey only
    output logic            o_last_round,   // round Nr, no MixColumns
    output logic            o_flag          // one-cycle completion pulse
);
    import aes_pkg::*;

    seq_state_e      state_q, state_d;
    logic [NR_W-1:0] round_q, round_d;
    logic [NR_W-1:0] nr_q, nr_d;
    logic [NR_W-1:0] nr_start;
    logic            busy_q;
    logic            armed_q;
    logic            start;
    logic            rcon_clear, rcon_load, rcon_step;

    // armed_q keeps a busy level that was already high across a reset from
    // looking like a fresh rising edge once reset releases: busy must be seen
    // low at least once after reset before a start is accepted.
    assign start = i_busy & ~busy_q & armed_q;

    always_comb begin
        case (i_key_len)
            KEY_LEN_192: nr_start = NR_W'(NR_192);
            KEY_LEN_256: nr_start = NR_W'(NR_256);
            default:     nr_start = NR_W'(NR_128);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            round_q <= '0;
            nr_q    <= NR_W'(NR_128);
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            busy_q  <= i_busy;
            armed_q <= armed_q | ~i_busy;
        end
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        nr_d       = nr_q;
        rcon_clear = 1'b0;
        rcon_load  = 1'b0;
        rcon_step  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d   = SEQ_INIT;
                    nr_d      = nr_start;
                    round_d   = '0;
                    rcon_load = 1'b1;
                end
            end
            SEQ_INIT: begin
                if (!i_busy) begin
                    state_d    = SEQ_IDLE;
                    round_d    = '0;
                    rcon_clear = 1'b1;
                end else if (!i_hold) begin
                    // round 1 uses RCON_INIT, so rcon is not stepped here
                    state_d = SEQ_ROUND;
                    round_d = NR_W'(1);
                end
            end
            SEQ_ROUND: begin
                if (!i_busy) begin
                    state_d    = SEQ_IDLE;
                    round_d    = '0;
                    rcon_clear = 1'b1;
                end else if (!i_hold) begin
                    if (round_q == nr_q) begin
                        state_d = SEQ_FLAG;
                    end else begin
                        round_d   = round_q + NR_W'(1);
                        rcon_step = 1'b1;
                    end
                end
            end
            SEQ_FLAG: begin
                state_d    = SEQ_IDLE;
                round_d    = '0;
                rcon_clear = 1'b1;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    aes_rcon_gen u_rcon_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (rcon_clear),
        .load  (rcon_load),
        .step  (rcon_step),
        .rcon  (o_rcon)
    );

    assign o_round       = round_q;
    assign o_first_round = (state_q == SEQ_INIT);
    assign o_last_round  = (state_q == SEQ_ROUND) && (round_q == nr_q);
    assign o_flag        = (state_q == SEQ_FLAG);
    assign o_round_en    = ((state_q == SEQ_INIT) || (state_q == SEQ_ROUND)) && !i_hold;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy_drv = 1'b0;
    logic       loop_mode = 1'b0;
    logic       en = 1'b0;
    logic       i_hold = 1'b0;
    logic [1:0] i_key_len = 2'd0;
    logic       i_busy;
    logic [3:0] o_round;
    logic [7:0] o_rcon;
    logic       o_round_en, o_first_round, o_last_round, o_flag;

    int checks = 0;
    int errors = 0;
    int flag_cnt = 0;

    logic [7:0] rcon_tbl [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

    always #5 clk = ~clk;

    // reference control FSM: WAIT -> BUSY on enable, BUSY -> DONE on flag, DONE -> WAIT
    typedef enum logic [1:0] {F_WAIT, F_BUSY, F_DONE} fsm_e;
    fsm_e fsm;
    always_ff @(posedge clk) begin
        if (rst) fsm <= F_WAIT;
        else begin
            case (fsm)
                F_WAIT:  if (en) fsm <= F_BUSY;
                F_BUSY:  if (o_flag) fsm <= F_DONE;
                default: fsm <= F_WAIT;
            endcase
        end
    end
    assign i_busy = loop_mode ? (fsm == F_BUSY) : busy_drv;

    always_ff @(posedge clk) begin
        if (o_flag) flag_cnt <= flag_cnt + 1;
    end

    aes_round_sequencer #(.NR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_busy        (i_busy),
        .i_key_len     (i_key_len),
        .i_hold        (i_hold),
        .o_round       (o_round),
        .o_rcon        (o_rcon),
        .o_round_en    (o_round_en),
        .o_first_round (o_first_round),
        .o_last_round  (o_last_round),
        .o_flag        (o_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " round"}, 32'(o_round), 32'd0);
        check({tag, " rcon"}, 32'(o_rcon), 32'd0);
        check({tag, " en"}, 32'(o_round_en), 32'd0);
        check({tag, " first"}, 32'(o_first_round), 32'd0);
        check({tag, " last"}, 32'(o_last_round), 32'd0);
        check({tag, " flag"}, 32'(o_flag), 32'd0);
    endtask

    // start with busy rising in cycle 0, walk rounds 1..nr, expect flag at nr+2
    task automatic run_nominal(input logic [1:0] kl, input int nr);
        busy_drv = 1'b0;
        tick;
        tick;
        i_key_len = kl;
        busy_drv  = 1'b1;
        tick;
        i_key_len = ~kl;
        #1;
        check("init first", 32'(o_first_round), 32'd1);
        check("init round", 32'(o_round), 32'd0);
        check("init rcon", 32'(o_rcon), 32'h01);
        check("init en", 32'(o_round_en), 32'd1);
        for (int r = 1; r <= nr; r++) begin
            tick;
            check("rnd round", 32'(o_round), 32'(r));
            check("rnd rcon", 32'(o_rcon), 32'(rcon_tbl[r-1]));
            check("rnd last", 32'(o_last_round), 32'(r == nr));
            check("rnd first", 32'(o_first_round), 32'd0);
            check("rnd flag", 32'(o_flag), 32'd0);
        end
        tick;
        check("flag at nr+2", 32'(o_flag), 32'd1);
        check("flag en", 32'(o_round_en), 32'd0);
        busy_drv = 1'b0;
        tick;
        check_idle("after flag");
    endtask

    initial begin
        int exp_r;
        int n;
        int base;
        logic hold_now;

        // reset state
        tick;
        tick;
        check_idle("reset");
        rst = 1'b0;
        tick;
        check_idle("post reset");

        // nominal runs, including key code 3 behaving as AES-128
        run_nominal(2'd0, 10);
        run_nominal(2'd1, 12);
        run_nominal(2'd2, 14);
        run_nominal(2'd3, 10);

        // holds: 3 cycles in INIT, 2 cycles at round 5, flag at cycle 17
        busy_drv = 1'b0;
        tick;
        busy_drv = 1'b1;
        tick;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc > 1) tick;
            hold_now = (cyc <= 3) || (cyc == 9) || (cyc == 10);
            i_hold = hold_now;
            #1;
            if (cyc <= 4) exp_r = 0;
            else if (cyc <= 9) exp_r = cyc - 4;
            else if (cyc <= 11) exp_r = 5;
            else exp_r = cyc - 6;
            check("hold en", 32'(o_round_en), 32'(!hold_now));
            check("hold round", 32'(o_round), 32'(exp_r));
            check("hold flag", 32'(o_flag), 32'd0);
            if (exp_r > 0) check("hold rcon", 32'(o_rcon), 32'(rcon_tbl[exp_r-1]));
        end
        i_hold = 1'b0;
        tick;
        check("hold flag@17", 32'(o_flag), 32'd1);
        busy_drv = 1'b0;
        tick;
        check_idle("hold done");

        // abort at round 4
        busy_drv = 1'b1;
        tick;
        tick;
        tick;
        tick;
        tick;
        check("abort pre round", 32'(o_round), 32'd4);
        busy_drv = 1'b0;
        tick;
        check_idle("abort");
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (o_flag) n++;
        end
        check("abort no flag", 32'(n), 32'd0);
        busy_drv = 1'b1;
        tick;
        check("restart first", 32'(o_first_round), 32'd1);
        check("restart round", 32'(o_round), 32'd0);
        check("restart rcon", 32'(o_rcon), 32'h01);

        // reset at round 7 with busy still high
        for (int i = 0; i < 7; i++) tick;
        check("pre rst round", 32'(o_round), 32'd7);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_idle("rst mid");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (o_first_round || o_flag || o_round != 4'd0) n++;
        end
        check("no restart on held busy", 32'(n), 32'd0);
        busy_drv = 1'b0;
        tick;
        tick;
        busy_drv = 1'b1;
        tick;
        check("rearm first", 32'(o_first_round), 32'd1);
        for (int i = 0; i < 11; i++) tick;
        check("rearm flag", 32'(o_flag), 32'd1);
        busy_drv = 1'b0;
        tick;

        // closed loop with the control FSM, three back-to-back enables
        i_key_len = 2'd0;
        loop_mode = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            base = flag_cnt;
            en = 1'b1;
            tick;
            en = 1'b0;
            n = 40;
            for (int i = 1; i <= 40; i++) begin
                tick;
                if (fsm == F_DONE) begin
                    n = i;
                    break;
                end
            end
            check("loop done latency", 32'(n), 32'd13);
            check("loop one flag", 32'(flag_cnt - base), 32'd1);
            tick;
            check("loop valid 1 cycle", 32'(fsm == F_DONE), 32'd0);
            check("loop idle", 32'(o_round_en), 32'd0);
        end
        loop_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
